// File: rtl/cnt_arb_pkg.sv
// Shared types and constants for the counter arbiter and its helpers.
package cnt_arb_pkg;

   // Engine states; encodings are shared with other counter-based blocks.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Count direction constants from the counter block; this engine only counts down.
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Width of a requester index; never less than one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cnt_arb_if.sv
// Request/grant bus between the requesters and the shared delay engine.
interface cnt_arb_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] len;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic [WIDTH-1:0]      cnt;

   // Requester side drives req/len and watches the engine.
   modport master (
      output req, len,
      input  gnt, done, busy, cnt
   );

   // Engine side.
   modport slave (
      input  req, len,
      output gnt, done, busy, cnt
   );
endinterface

// File: rtl/cnt_arb_rr_pick.sv
// Combinational round-robin selector: first set request strictly after 'last', with wrap.
module rr_pick
   import cnt_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = ptr_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   last,
   output logic [PW-1:0]   win,
   output logic [NREQ-1:0] onehot,
   output logic            valid
);

   // One spare bit so last+1+i never overflows before the wrap back below NREQ.
   logic [PW:0] idx;

   // Scan candidates last+1 .. last+NREQ modulo NREQ and keep the first hit.
   always_comb begin
      win    = '0;
      onehot = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = {1'b0, last} + (PW+1)'(i + 1);
         if (idx >= (PW+1)'(NREQ)) begin
            idx = idx - (PW+1)'(NREQ);
         end
         if (!valid && req[idx[PW-1:0]]) begin
            valid                 = 1'b1;
            win                   = idx[PW-1:0];
            onehot[idx[PW-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cnt_arb.sv
// Shared down-counting delay engine with round-robin access for NREQ requesters.
module cnt_arb
   import cnt_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic      clk,
   input  logic      rstn,
   cnt_arb_if.slave  bus
);

   localparam int PW = ptr_w(NREQ);

   state_e            state_q, state_d;
   logic [PW-1:0]     last_q, last_d;
   logic [WIDTH-1:0]  cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              busy_q, busy_d;

   logic [PW-1:0]     pick_idx;
   logic [NREQ-1:0]   pick_oh;
   logic              pick_vld;
   logic [WIDTH-1:0]  len_sel;
   logic [NREQ-1:0]   own_oh;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req    (bus.req),
      .last   (last_q),
      .win    (pick_idx),
      .onehot (pick_oh),
      .valid  (pick_vld)
   );

   // While running, last_q is the current owner, so its one-hot doubles as the done target.
   assign own_oh = NREQ'(1) << last_q;

   // Select the winner's length; it is only captured on the grant edge.
   always_comb begin
      len_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == PW'(i)) begin
            len_sel = bus.len[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state and output logic; abort beats completion when both apply.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gnt_d   = pick_oh;
               cnt_d   = len_sel;
               last_d  = pick_idx;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!bus.req[last_q]) begin
               gnt_d   = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               gnt_d   = '0;
               done_d  = own_oh;
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q - WIDTH'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, pointer, counter and output registers; reset puts requester 0 first in line.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         last_q  <= PW'(NREQ - 1);
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;
   assign bus.cnt  = cnt_q;

endmodule

// File: tb/tb_cnt_arb.sv
// Self-checking bench for cnt_arb against a grant-level reference model.
module tb_cnt_arb;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   cnt_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus_if ();

   cnt_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model: a grant is (owner, edge it was granted on, length); outputs derive from that.
   int m_owner, m_gcyc, m_glen, m_last, m_done_own;
   logic [NREQ-1:0]  exp_gnt, exp_done;
   logic [WIDTH-1:0] exp_cnt;
   logic             exp_busy;

   logic [NREQ-1:0] drop_mask;
   logic [NREQ-1:0] prev_gnt;
   int obs_gnt_cyc[NREQ];
   int obs_done[NREQ];
   int gnt_order[$];

   task automatic model_reset();
      m_owner = -1; m_done_own = -1; m_last = NREQ - 1; m_gcyc = 0; m_glen = 0;
      exp_gnt = '0; exp_done = '0; exp_cnt = '0; exp_busy = 1'b0;
   endtask

   task automatic clear_obs();
      for (int i = 0; i < NREQ; i++) begin obs_gnt_cyc[i] = 0; obs_done[i] = 0; end
      gnt_order.delete();
      prev_gnt = '0;
   endtask

   task automatic model_step();
      int shown;
      int c;
      if (m_owner >= 0) begin
         shown = m_glen - (cyc - 1 - m_gcyc);
         if (bus_if.req[m_owner] !== 1'b1) m_owner = -1;
         else if (shown == 0) begin m_done_own = m_owner; m_owner = -1; end
      end else if (m_done_own >= 0) begin
         m_done_own = -1;
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (m_owner < 0 && bus_if.req[c] === 1'b1) begin
               m_owner = c; m_gcyc = cyc; m_last = c;
               m_glen = int'(bus_if.len[c*WIDTH +: WIDTH]);
            end
         end
      end
      exp_gnt  = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
      exp_done = (m_done_own >= 0) ? (NREQ'(1) << m_done_own) : '0;
      exp_cnt  = (m_owner >= 0) ? WIDTH'(m_glen - (cyc - m_gcyc)) : '0;
      exp_busy = (m_owner >= 0) || (m_done_own >= 0);
   endtask

   // One clock: model advances on the edge, DUT sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      checks++;
      if (bus_if.gnt !== exp_gnt) begin errors++; $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, bus_if.gnt, exp_gnt); end
      checks++;
      if (bus_if.done !== exp_done) begin errors++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, bus_if.done, exp_done); end
      checks++;
      if (bus_if.cnt !== exp_cnt) begin errors++; $display("FAIL cnt cyc=%0d got=%0d exp=%0d", cyc, bus_if.cnt, exp_cnt); end
      checks++;
      if (bus_if.busy !== exp_busy) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus_if.busy, exp_busy); end
      checks++;
      if (!$onehot0(bus_if.gnt) || ((bus_if.gnt & bus_if.done) != '0)) begin
         errors++; $display("FAIL exclusive cyc=%0d gnt=%b done=%b required onehot0 and disjoint", cyc, bus_if.gnt, bus_if.done);
      end
      for (int i = 0; i < NREQ; i++) begin
         if (bus_if.gnt[i] === 1'b1) begin
            obs_gnt_cyc[i]++;
            if (prev_gnt[i] !== 1'b1) gnt_order.push_back(i);
         end
         if (bus_if.done[i] === 1'b1) obs_done[i]++;
      end
      prev_gnt = bus_if.gnt;
      bus_if.req = bus_if.req & ~(exp_done & drop_mask);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      bus_if.req = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      clear_obs();
   endtask

   task automatic test_reset();
      bus_if.req = '1;
      for (int i = 0; i < NREQ; i++) bus_if.len[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(255, 0));
      repeat (2) @(negedge clk);
      checks++; if (bus_if.gnt !== '0)  begin errors++; $display("FAIL reset_gnt got=%b exp=0", bus_if.gnt); end
      checks++; if (bus_if.done !== '0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus_if.done); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
      checks++; if (bus_if.cnt !== '0)  begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus_if.cnt); end
      do_reset();
   endtask

   task automatic test_basic();
      int done_at;
      int regrant_at;
      do_reset();
      drop_mask = '1;
      bus_if.len[0 +: WIDTH] = WIDTH'(3);
      bus_if.req = 4'b0001;
      tick();
      bus_if.len[0 +: WIDTH] = WIDTH'(9);
      done_at = -1;
      for (int n = 0; n < 20 && done_at < 0; n++) begin
         tick();
         if (bus_if.done[0] === 1'b1) done_at = cyc;
      end
      checks++; if (done_at < 0) begin errors++; $display("FAIL basic_done_timeout got=none exp=pulse"); end
      checks++; if (obs_gnt_cyc[0] != 4) begin errors++; $display("FAIL basic_gnt_len got=%0d exp=4", obs_gnt_cyc[0]); end
      checks++; if (obs_done[0] != 1) begin errors++; $display("FAIL basic_done_cnt got=%0d exp=1", obs_done[0]); end
      tick();
      bus_if.req[0] = 1'b1;
      regrant_at = -1;
      for (int n = 0; n < 6 && regrant_at < 0; n++) begin
         tick();
         if (bus_if.gnt[0] === 1'b1) regrant_at = cyc;
      end
      checks++;
      if (regrant_at - done_at != 2) begin errors++; $display("FAIL basic_regrant_gap got=%0d exp=2", regrant_at - done_at); end
      bus_if.req = '0;
   endtask

   task automatic test_rr_len0();
      int exp_ord[4] = '{0, 1, 2, 3};
      do_reset();
      drop_mask = '1;
      for (int i = 0; i < NREQ; i++) bus_if.len[i*WIDTH +: WIDTH] = '0;
      bus_if.req = '1;
      repeat (14) tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= gnt_order.size() || gnt_order[i] != exp_ord[i]) begin
            errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, (i < gnt_order.size()) ? gnt_order[i] : -1, exp_ord[i]);
         end
         checks++;
         if (obs_gnt_cyc[i] != 1 || obs_done[i] != 1) begin
            errors++; $display("FAIL rr_pulses[%0d] gnt_cycles=%0d done=%0d exp=1/1", i, obs_gnt_cyc[i], obs_done[i]);
         end
      end
   endtask

   task automatic test_abort();
      do_reset();
      drop_mask = '1;
      bus_if.len[1*WIDTH +: WIDTH] = WIDTH'(10);
      bus_if.len[2*WIDTH +: WIDTH] = WIDTH'($urandom_range(5, 0));
      bus_if.req = 4'b0110;
      repeat (3) tick();
      bus_if.req[1] = 1'b0;
      tick();
      checks++; if (bus_if.gnt !== '0) begin errors++; $display("FAIL abort_gnt got=%b exp=0", bus_if.gnt); end
      checks++; if (bus_if.cnt !== '0) begin errors++; $display("FAIL abort_cnt got=%0d exp=0", bus_if.cnt); end
      repeat (12) tick();
      checks++; if (obs_done[1] != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", obs_done[1]); end
      checks++;
      if (gnt_order.size() < 2 || gnt_order[0] != 1 || gnt_order[1] != 2) begin
         errors++; $display("FAIL abort_next_grant got_count=%0d exp=order 1 then 2", gnt_order.size());
      end
      checks++; if (obs_done[2] != 1) begin errors++; $display("FAIL abort_done2 got=%0d exp=1", obs_done[2]); end
   endtask

   task automatic test_hold();
      int exp_ord[3] = '{0, 2, 0};
      do_reset();
      drop_mask = 4'b1110;
      for (int i = 0; i < NREQ; i++) bus_if.len[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(3, 0));
      bus_if.req = 4'b0101;
      repeat (20) tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= gnt_order.size() || gnt_order[i] != exp_ord[i]) begin
            errors++; $display("FAIL hold_order[%0d] got=%0d exp=%0d", i, (i < gnt_order.size()) ? gnt_order[i] : -1, exp_ord[i]);
         end
      end
      bus_if.req = '0;
   endtask

   task automatic test_reset_mid();
      bit found;
      int got;
      do_reset();
      drop_mask = '1;
      bus_if.len[0 +: WIDTH] = WIDTH'(20);
      bus_if.req = 4'b0001;
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         tick();
         if (exp_gnt[0] && exp_cnt == WIDTH'(5)) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL midrst_reach_cnt5 got=none exp=cnt 5"); end
      #2 rstn = 1'b0;
      #1;
      checks++; if (bus_if.gnt !== '0)  begin errors++; $display("FAIL midrst_gnt got=%b exp=0", bus_if.gnt); end
      checks++; if (bus_if.done !== '0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus_if.done); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus_if.busy); end
      checks++; if (bus_if.cnt !== '0)  begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", bus_if.cnt); end
      model_reset();
      bus_if.req = '0;
      @(negedge clk);
      rstn = 1'b1;
      clear_obs();
      for (int i = 0; i < NREQ; i++) bus_if.len[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(4, 0));
      bus_if.req = 4'b1010;
      for (int n = 0; n < 5 && gnt_order.size() == 0; n++) tick();
      got = (gnt_order.size() > 0) ? gnt_order[0] : -1;
      checks++; if (got != 1) begin errors++; $display("FAIL midrst_first_grant got=%0d exp=1", got); end
      bus_if.req = '0;
   endtask

   task automatic test_max_len();
      do_reset();
      drop_mask = '1;
      bus_if.len[0 +: WIDTH] = '1;
      bus_if.req = 4'b0001;
      for (int n = 0; n < 300 && obs_done[0] == 0; n++) tick();
      repeat (3) tick();
      checks++; if (obs_gnt_cyc[0] != 256) begin errors++; $display("FAIL max_gnt_len got=%0d exp=256", obs_gnt_cyc[0]); end
      checks++; if (obs_done[0] != 1) begin errors++; $display("FAIL max_done_cnt got=%0d exp=1", obs_done[0]); end
      checks++; if (bus_if.cnt !== '0) begin errors++; $display("FAIL max_cnt_end got=%0d exp=0", bus_if.cnt); end
   endtask

   task automatic test_random();
      int total_done;
      do_reset();
      drop_mask = '1;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(7, 0) == 0) bus_if.len[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(12, 0));
            if (bus_if.req[i] == 1'b0) begin
               if ($urandom_range(5, 0) == 0) bus_if.req[i] = 1'b1;
            end else if ($urandom_range(39, 0) == 0) begin
               bus_if.req[i] = 1'b0;
            end
         end
         tick();
      end
      total_done = 0;
      for (int i = 0; i < NREQ; i++) total_done += obs_done[i];
      checks++; if (total_done < 10) begin errors++; $display("FAIL random_activity got=%0d dones exp>=10", total_done); end
      bus_if.req = '0;
   endtask

   initial begin
      bus_if.req = '0;
      bus_if.len = '0;
      drop_mask  = '1;
      model_reset();
      clear_obs();
      test_reset();
      test_basic();
      test_rr_len0();
      test_abort();
      test_hold();
      test_reset_mid();
      test_max_len();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
